// File: rtl/alu_control_sequencer.sv
// -----------------------------------------------------------------------------
// alu_control_sequencer
//
// Hardwired control unit for the register-to-register datapath. It steps the
// datapath through instruction fetch (T0-T2) and the execute steps (T3-T6) of
// the ALU, unary and MUL/DIV instructions. It decodes the opcode in IR[31:27]
// and drives the per-step strobes that the datapath would otherwise need from
// a testbench.
//
// Ports
//   clock        system clock; all state changes on the rising edge
//   clear        synchronous active-high reset (state -> IDLE, count -> 0)
//   IR           instruction register from the datapath; opcode = IR[31:27]
//   mem_ready    memory read data valid; only looked at in T1
//   PCout..Yin   datapath transfer strobes
//   Zlowin..LOin Z / HI / LO register strobes
//   Gra..Rout    register-field select and direction for select-and-encode
//   ADD..DIV     one-hot ALU operation, high only in the step that loads Zlow
//   run          high while sequencing (T0-T6), low in IDLE and HALT
//   illegal      single-cycle pulse in T3 for an unsupported opcode
//   instr_count  retired-instruction counter, wraps at 16 bits
//
// Configuration
//   ALU_CTRL_MULDIV_EN  when defined, MUL/DIV are decoded and T6 plus the
//                       HI/LO/Zhigh strobes are live. When undefined, MUL/DIV
//                       opcodes take the illegal path and those outputs stay 0.
// -----------------------------------------------------------------------------
module alu_control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        mem_ready,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        PCin,
    output logic        MDMuxread,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zlowin,
    output logic        Zhighin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIin,
    output logic        LOin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        ADD,
    output logic        SUB,
    output logic        AND,
    output logic        OR,
    output logic        SHR,
    output logic        SHRA,
    output logic        SHL,
    output logic        ROR,
    output logic        ROL,
    output logic        NEG,
    output logic        NOT,
    output logic        MUL,
    output logic        DIV,
    output logic        run,
    output logic        illegal,
    output logic [15:0] instr_count
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_BINARY, CLS_MULDIV, CLS_UNARY, CLS_HALT, CLS_ILLEGAL
    } op_class_t;

    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_SUB  = 5'b00100;
    localparam logic [4:0] OPC_AND  = 5'b00101;
    localparam logic [4:0] OPC_OR   = 5'b00110;
    localparam logic [4:0] OPC_ROR  = 5'b00111;
    localparam logic [4:0] OPC_ROL  = 5'b01000;
    localparam logic [4:0] OPC_SHR  = 5'b01001;
    localparam logic [4:0] OPC_SHRA = 5'b01010;
    localparam logic [4:0] OPC_SHL  = 5'b01011;
    localparam logic [4:0] OPC_DIV  = 5'b01111;
    localparam logic [4:0] OPC_MUL  = 5'b10000;
    localparam logic [4:0] OPC_NEG  = 5'b10001;
    localparam logic [4:0] OPC_NOT  = 5'b10010;
    localparam logic [4:0] OPC_HALT = 5'b11011;

    state_t    state;
    state_t    next_state;
    op_class_t op_class;
    logic [4:0] opcode;
    logic       op_en;    // this step carries Zlowin for the ALU operation
    logic       retire;   // leaving the final execute step of a counted instruction

    // Register fields of IR are consumed by the datapath decoder, not here.
    logic unused_ir_fields;
    assign unused_ir_fields = ^IR[26:0];

    assign opcode = IR[31:27];

    // Instruction class from the opcode; anything not listed is illegal.
    always_comb begin
        op_class = CLS_ILLEGAL;
        case (opcode)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_ROR,
            OPC_ROL, OPC_SHR, OPC_SHRA, OPC_SHL:         op_class = CLS_BINARY;
`ifdef ALU_CTRL_MULDIV_EN
            OPC_DIV, OPC_MUL:                            op_class = CLS_MULDIV;
`endif
            OPC_NEG, OPC_NOT:                            op_class = CLS_UNARY;
            OPC_HALT:                                    op_class = CLS_HALT;
            default:                                     op_class = CLS_ILLEGAL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs regardless of process order.
    always_ff @(posedge clock) begin
        if (clear) state <= S_IDLE;
        else       state <= next_state;
    end

    always_ff @(posedge clock) begin
        if (clear)       instr_count <= 16'd0;
        else if (retire) instr_count <= instr_count + 16'd1;
    end

    // NOTE: every output of this block gets a default first, so no path through
    // the case statements can leave a value unassigned and infer a latch.
    always_comb begin
        next_state = state;
        op_en      = 1'b0;
        retire     = 1'b0;
        run        = 1'b0;
        illegal    = 1'b0;
        PCout      = 1'b0;  MARin    = 1'b0;  IncPC    = 1'b0;  PCin   = 1'b0;
        MDMuxread  = 1'b0;  MDRin    = 1'b0;  MDRout   = 1'b0;  IRin   = 1'b0;
        Yin        = 1'b0;  Zlowin   = 1'b0;  Zhighin  = 1'b0;  Zlowout = 1'b0;
        Zhighout   = 1'b0;  HIin     = 1'b0;  LOin     = 1'b0;
        Gra        = 1'b0;  Grb      = 1'b0;  Grc      = 1'b0;  Rin    = 1'b0;
        Rout       = 1'b0;

        case (state)
            S_IDLE: next_state = S_T0;

            S_T0: begin
                run = 1'b1;
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1;
                next_state = S_T1;
            end

            // Strobes stay up while waiting for memory; reloading PC from the
            // same Z value on each wait cycle is harmless.
            S_T1: begin
                run = 1'b1;
                Zlowout = 1'b1; PCin = 1'b1; MDMuxread = 1'b1; MDRin = 1'b1;
                if (mem_ready) next_state = S_T2;
            end

            S_T2: begin
                run = 1'b1;
                MDRout = 1'b1; IRin = 1'b1;
                next_state = S_T3;
            end

            S_T3: begin
                run = 1'b1;
                case (op_class)
                    CLS_BINARY, CLS_MULDIV: begin
                        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                        next_state = S_T4;
                    end
                    CLS_UNARY: begin
                        Grb = 1'b1; Rout = 1'b1; Zlowin = 1'b1; op_en = 1'b1;
                        next_state = S_T4;
                    end
                    CLS_HALT: next_state = S_HALT;
                    default: begin
                        illegal    = 1'b1;
                        next_state = S_T0;
                    end
                endcase
            end

            S_T4: begin
                run = 1'b1;
                next_state = S_T0;
                case (op_class)
                    CLS_BINARY: begin
                        Grc = 1'b1; Rout = 1'b1; Zlowin = 1'b1; op_en = 1'b1;
                        next_state = S_T5;
                    end
`ifdef ALU_CTRL_MULDIV_EN
                    CLS_MULDIV: begin
                        Grc = 1'b1; Rout = 1'b1; Zlowin = 1'b1; Zhighin = 1'b1;
                        op_en = 1'b1;
                        next_state = S_T5;
                    end
`endif
                    CLS_UNARY: begin
                        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                        retire = 1'b1;
                    end
                    default: ;
                endcase
            end

            S_T5: begin
                run = 1'b1;
                next_state = S_T0;
                case (op_class)
                    CLS_BINARY: begin
                        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                        retire = 1'b1;
                    end
`ifdef ALU_CTRL_MULDIV_EN
                    CLS_MULDIV: begin
                        Zlowout = 1'b1; LOin = 1'b1;
                        next_state = S_T6;
                    end
`endif
                    default: ;
                endcase
            end

            S_T6: begin
                run = 1'b1;
                next_state = S_T0;
`ifdef ALU_CTRL_MULDIV_EN
                Zhighout = 1'b1; HIin = 1'b1;
                retire = 1'b1;
`endif
            end

            S_HALT: next_state = S_HALT;

            default: next_state = S_IDLE;
        endcase
    end

    // One-hot ALU operation, only in the step that loads Zlow for it.
    always_comb begin
        ADD = 1'b0; SUB = 1'b0; AND = 1'b0; OR   = 1'b0; SHR = 1'b0;
        SHRA = 1'b0; SHL = 1'b0; ROR = 1'b0; ROL = 1'b0; NEG = 1'b0;
        NOT = 1'b0; MUL = 1'b0; DIV = 1'b0;
        if (op_en) begin
            case (opcode)
                OPC_ADD:  ADD  = 1'b1;
                OPC_SUB:  SUB  = 1'b1;
                OPC_AND:  AND  = 1'b1;
                OPC_OR:   OR   = 1'b1;
                OPC_ROR:  ROR  = 1'b1;
                OPC_ROL:  ROL  = 1'b1;
                OPC_SHR:  SHR  = 1'b1;
                OPC_SHRA: SHRA = 1'b1;
                OPC_SHL:  SHL  = 1'b1;
`ifdef ALU_CTRL_MULDIV_EN
                OPC_DIV:  DIV  = 1'b1;
                OPC_MUL:  MUL  = 1'b1;
`endif
                OPC_NEG:  NEG  = 1'b1;
                OPC_NOT:  NOT  = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_control_sequencer
//
// Self-checking bench. For each instruction a reference model builds the
// expected per-cycle strobe sets straight from the instruction-class rules
// (fetch, then the class-specific execute steps) and compares them cycle by
// cycle, along with the retired-instruction count.
// -----------------------------------------------------------------------------
module tb_alu_control_sequencer;

`ifdef ALU_CTRL_MULDIV_EN
    localparam bit MULDIV_EN = 1'b1;
`else
    localparam bit MULDIV_EN = 1'b0;
`endif

    // Bit positions of the packed observation vector.
    localparam logic [34:0] M_PCOUT    = 35'd1 << 0;
    localparam logic [34:0] M_MARIN    = 35'd1 << 1;
    localparam logic [34:0] M_INCPC    = 35'd1 << 2;
    localparam logic [34:0] M_PCIN     = 35'd1 << 3;
    localparam logic [34:0] M_MDMUX    = 35'd1 << 4;
    localparam logic [34:0] M_MDRIN    = 35'd1 << 5;
    localparam logic [34:0] M_MDROUT   = 35'd1 << 6;
    localparam logic [34:0] M_IRIN     = 35'd1 << 7;
    localparam logic [34:0] M_YIN      = 35'd1 << 8;
    localparam logic [34:0] M_ZLOWIN   = 35'd1 << 9;
    localparam logic [34:0] M_ZHIGHIN  = 35'd1 << 10;
    localparam logic [34:0] M_ZLOWOUT  = 35'd1 << 11;
    localparam logic [34:0] M_ZHIGHOUT = 35'd1 << 12;
    localparam logic [34:0] M_HIIN     = 35'd1 << 13;
    localparam logic [34:0] M_LOIN     = 35'd1 << 14;
    localparam logic [34:0] M_GRA      = 35'd1 << 15;
    localparam logic [34:0] M_GRB      = 35'd1 << 16;
    localparam logic [34:0] M_GRC      = 35'd1 << 17;
    localparam logic [34:0] M_RIN      = 35'd1 << 18;
    localparam logic [34:0] M_ROUT     = 35'd1 << 19;
    localparam logic [34:0] M_ADD      = 35'd1 << 20;
    localparam logic [34:0] M_SUB      = 35'd1 << 21;
    localparam logic [34:0] M_AND      = 35'd1 << 22;
    localparam logic [34:0] M_OR       = 35'd1 << 23;
    localparam logic [34:0] M_SHR      = 35'd1 << 24;
    localparam logic [34:0] M_SHRA     = 35'd1 << 25;
    localparam logic [34:0] M_SHL      = 35'd1 << 26;
    localparam logic [34:0] M_ROR      = 35'd1 << 27;
    localparam logic [34:0] M_ROL      = 35'd1 << 28;
    localparam logic [34:0] M_NEG      = 35'd1 << 29;
    localparam logic [34:0] M_NOT      = 35'd1 << 30;
    localparam logic [34:0] M_MUL      = 35'd1 << 31;
    localparam logic [34:0] M_DIV      = 35'd1 << 32;
    localparam logic [34:0] M_ILLEGAL  = 35'd1 << 33;
    localparam logic [34:0] M_RUN      = 35'd1 << 34;

    localparam int K_BIN = 0, K_MULDIV = 1, K_UNARY = 2, K_HALT = 3, K_ILLEGAL = 4;

    logic        clock;
    logic        clear;
    logic [31:0] IR;
    logic        mem_ready;
    logic PCout, MARin, IncPC, PCin, MDMuxread, MDRin, MDRout, IRin, Yin;
    logic Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin;
    logic Gra, Grb, Grc, Rin, Rout;
    logic ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, MUL, DIV;
    logic run, illegal;
    logic [15:0] instr_count;

    logic [34:0] obs;
    logic [15:0] model_count;
    int          n_checks;
    int          n_errors;

    alu_control_sequencer dut (
        .clock(clock), .clear(clear), .IR(IR), .mem_ready(mem_ready),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin),
        .MDMuxread(MDMuxread), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .Yin(Yin), .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout),
        .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .SHR(SHR), .SHRA(SHRA),
        .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT), .MUL(MUL),
        .DIV(DIV), .run(run), .illegal(illegal), .instr_count(instr_count)
    );

    assign obs = {run, illegal, DIV, MUL, NOT, NEG, ROL, ROR, SHL, SHRA, SHR,
                  OR, AND, SUB, ADD, Rout, Rin, Grc, Grb, Gra, LOin, HIin,
                  Zhighout, Zlowout, Zhighin, Zlowin, Yin, IRin, MDRout, MDRin,
                  MDMuxread, PCin, IncPC, MARin, PCout};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: instruction class and ALU op line from the opcode.
    // ------------------------------------------------------------------
    function automatic int kind_of(input logic [4:0] opc);
        case (opc)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: return K_BIN;
            5'd15, 5'd16: return MULDIV_EN ? K_MULDIV : K_ILLEGAL;
            5'd17, 5'd18: return K_UNARY;
            5'd27:        return K_HALT;
            default:      return K_ILLEGAL;
        endcase
    endfunction

    function automatic logic [34:0] op_mask(input logic [4:0] opc);
        case (opc)
            5'd3:  return M_ADD;
            5'd4:  return M_SUB;
            5'd5:  return M_AND;
            5'd6:  return M_OR;
            5'd7:  return M_ROR;
            5'd8:  return M_ROL;
            5'd9:  return M_SHR;
            5'd10: return M_SHRA;
            5'd11: return M_SHL;
            5'd15: return M_DIV;
            5'd16: return M_MUL;
            5'd17: return M_NEG;
            5'd18: return M_NOT;
            default: return '0;
        endcase
    endfunction

    // One idle/halted cycle: everything low, counter as modelled.
    task automatic quiet_cycle(input string tag);
        mem_ready = 1'($urandom);
        @(negedge clock);
        check(tag, 64'(obs), 64'd0);
        check({tag, "_count"}, 64'(instr_count), 64'(model_count));
        @(posedge clock);
        #1;
    endtask

    // Runs one instruction starting in T0. When abort_t4 is set, clear is
    // raised during the fifth step (T4) and the run stops after that edge.
    task automatic run_instr(input logic [31:0] ir_val, input int stalls, input bit abort_t4);
        logic [34:0] seq[$];
        logic [4:0]  opc;
        logic [34:0] op;
        int          kind;
        int          t4_idx;
        opc  = ir_val[31:27];
        kind = kind_of(opc);
        op   = op_mask(opc);

        seq.push_back(M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN);
        for (int i = 0; i <= stalls; i++)
            seq.push_back(M_RUN | M_ZLOWOUT | M_PCIN | M_MDMUX | M_MDRIN);
        seq.push_back(M_RUN | M_MDROUT | M_IRIN);
        case (kind)
            K_BIN: begin
                seq.push_back(M_RUN | M_GRB | M_ROUT | M_YIN);
                seq.push_back(M_RUN | M_GRC | M_ROUT | op | M_ZLOWIN);
                seq.push_back(M_RUN | M_ZLOWOUT | M_GRA | M_RIN);
            end
            K_MULDIV: begin
                seq.push_back(M_RUN | M_GRB | M_ROUT | M_YIN);
                seq.push_back(M_RUN | M_GRC | M_ROUT | op | M_ZLOWIN | M_ZHIGHIN);
                seq.push_back(M_RUN | M_ZLOWOUT | M_LOIN);
                seq.push_back(M_RUN | M_ZHIGHOUT | M_HIIN);
            end
            K_UNARY: begin
                seq.push_back(M_RUN | M_GRB | M_ROUT | op | M_ZLOWIN);
                seq.push_back(M_RUN | M_ZLOWOUT | M_GRA | M_RIN);
            end
            K_HALT:  seq.push_back(M_RUN);
            default: seq.push_back(M_RUN | M_ILLEGAL);
        endcase

        t4_idx = stalls + 4;
        IR = ir_val;
        for (int i = 0; i < seq.size(); i++) begin
            if (i >= 1 && i <= stalls)  mem_ready = 1'b0;
            else if (i == stalls + 1)   mem_ready = 1'b1;
            else                        mem_ready = 1'($urandom);
            clear = abort_t4 && (i == t4_idx);
            @(negedge clock);
            check($sformatf("strobes_op%0d_step%0d", opc, i), 64'(obs), 64'(seq[i]));
            check("count", 64'(instr_count), 64'(model_count));
            @(posedge clock);
            #1;
            if (clear) begin
                clear = 1'b0;
                model_count = 16'd0;
                return;
            end
        end
        if (kind == K_BIN || kind == K_MULDIV || kind == K_UNARY)
            model_count = model_count + 16'd1;
    endtask

    logic [4:0] legal_ops [13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                   5'd10, 5'd11, 5'd15, 5'd16, 5'd17, 5'd18};

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        model_count = 16'd0;
        clear       = 1'b1;
        IR          = 32'd0;
        mem_ready   = 1'b0;

        // Reset for two cycles, then one IDLE cycle before the first T0.
        repeat (2) @(posedge clock);
        #1;
        clear = 1'b0;
        quiet_cycle("reset_idle");

        // Directed cases.
        run_instr(32'h2091_8000, 0, 1'b0);   // SUB R1,R2,R3
        check("count_after_sub", 64'(instr_count), 64'd1);
        run_instr(32'h2091_8000, 3, 1'b0);   // same, three wait cycles in T1
        run_instr(32'h8890_0000, 0, 1'b0);   // NEG R1,R2
        run_instr(32'hF800_0000, 1, 1'b0);   // unsupported opcode 11111
        run_instr(32'h8091_8000, 0, 1'b0);   // MUL, or illegal without the option
        run_instr(32'h7891_8000, 2, 1'b0);   // DIV, or illegal without the option

        // Randomized instruction stream.
        for (int n = 0; n < 60; n++) begin
            logic [4:0] opc;
            if ($urandom_range(0, 4) == 0) begin
                opc = 5'($urandom);
                if (opc == 5'd27) opc = 5'd31;
            end else begin
                opc = legal_ops[$urandom_range(0, 12)];
            end
            run_instr({opc, 27'($urandom)}, $urandom_range(0, 3), 1'b0);
        end

        // Clear during T4 of a SUB: next cycle is IDLE with no Rin.
        run_instr(32'h2091_8000, 1, 1'b1);
        quiet_cycle("abort_idle");

        // HALT: stays quiet with run low until clear.
        run_instr(32'hD800_0000, 0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            IR = $urandom;
            quiet_cycle("halt_hold");
        end
        clear = 1'b1;
        quiet_cycle("halt_clear");
        clear = 1'b0;
        model_count = 16'd0;
        quiet_cycle("post_halt_idle");
        run_instr(32'h1891_8000, 0, 1'b0);   // ADD after recovery
        check("count_after_recover", 64'(instr_count), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
